// File: rtl/multicycle_riscv_core.sv
// Multicycle RV-subset core with a single shared memory port for fetch and load/store.
// Instructions walk FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB); illegal encodings stop the core.
module multicycle_riscv_core #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] pc_out
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] LS_F3     = (XLEN == 64) ? 3'b011 : 3'b010;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] regs [32];

    // Instruction fields and immediates, decoded straight from the IR
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_s  = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    logic is_r;
    logic is_addi;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic legal;

    assign is_r      = (opcode == OP_R) &&
                       (((funct7 == 7'b0000000) &&
                         ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                        ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    assign is_addi   = (opcode == OP_IMM) && (funct3 == 3'b000);
    assign is_load   = (opcode == OP_LOAD) && (funct3 == LS_F3);
    assign is_store  = (opcode == OP_STORE) && (funct3 == LS_F3);
    assign is_branch = (opcode == OP_BRANCH) && ((funct3 == 3'b000) || (funct3 == 3'b001));
    assign legal     = is_r || is_addi || is_load || is_store || is_branch;

    // ALU: R-type ops, otherwise rs1 + imm (addi and effective address)
    logic [XLEN-1:0] alu_c;
    always_comb begin
        alu_c = op_a + imm;
        if (is_r) begin
            case (funct3)
                3'b111:  alu_c = op_a & op_b;
                3'b110:  alu_c = op_a | op_b;
                default: alu_c = funct7[5] ? (op_a - op_b) : (op_a + op_b);
            endcase
        end
    end

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_branch;
    logic            taken;

    assign pc_plus4  = pc + XLEN'(4);
    assign taken     = (funct3 == 3'b000) ? (op_a == op_b) : (op_a != op_b);
    assign pc_branch = taken ? (pc + imm) : pc_plus4;
    assign pc_out    = pc;

    // Main FSM; memory outputs are set up on the edge that enters the state using them
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            imm       <= '0;
            alu       <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            retire    <= 1'b0;
            halted    <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!mem_req) begin
                        // first fetch after reset has to raise the request itself
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata[31:0];
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a   <= regs[rs1];
                    op_b   <= regs[rs2];
                    imm    <= is_store ? imm_s : (is_branch ? imm_b : imm_i);
                    halted <= !legal;
                    state  <= legal ? S_EXECUTE : S_HALT;
                end
                S_EXECUTE: begin
                    alu <= alu_c;
                    if (is_branch) begin
                        pc       <= pc_branch;
                        retire   <= 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_branch;
                        state    <= S_FETCH;
                    end else if (is_load || is_store) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= alu_c;
                        mem_wdata <= op_b;
                        state     <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (is_store) begin
                            pc       <= pc_plus4;
                            retire   <= 1'b1;
                            mem_addr <= pc_plus4;
                            state    <= S_FETCH;
                        end else begin
                            alu     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 5'd0) regs[rd] <= alu;
                    pc       <= pc_plus4;
                    retire   <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc_plus4;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    mem_req <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    halted  <= 1'b1;
                    state   <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_riscv_core.sv
// Directed bench: small program in a byte-addressed model memory, checks latency, stores, branches, halt, reset.
module tb_multicycle_riscv_core;

    localparam int unsigned XLEN  = 64;
    localparam logic [2:0]  LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;
    localparam logic [63:0] MINUS2 = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0000_0000_FFFF_FFFE;

    logic            clk;
    logic            reset;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            retire;
    logic            halted;
    logic [XLEN-1:0] pc_out;

    multicycle_riscv_core #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .halted    (halted),
        .pc_out    (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed little-endian model memory; program loaded through the same write process
    logic [7:0]      mem [256];
    logic            prog_we;
    logic [7:0]      prog_addr;
    logic [31:0]     prog_data;
    logic [XLEN-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    int              wr_count;

    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < int'(XLEN / 8); i++)
            mem_rdata[i*8 +: 8] = mem[mem_addr[7:0] + 8'(i)];
    end

    always @(posedge clk) begin
        if (prog_we) begin
            for (int i = 0; i < 4; i++) mem[prog_addr + 8'(i)] <= prog_data[i*8 +: 8];
        end else if (reset && mem_req && mem_we && mem_ready) begin
            for (int i = 0; i < int'(XLEN / 8); i++) mem[mem_addr[7:0] + 8'(i)] <= mem_wdata[i*8 +: 8];
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic put32(input logic [7:0] a, input logic [31:0] w);
        prog_addr = a;
        prog_data = w;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    // Cycles until the next retire pulse, bounded
    task automatic wait_retire(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!retire && n < 40);
        check(tag, 64'(n), 64'(exp_lat));
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    initial begin
        int n;
        reset     = 1'b0;
        mem_ready = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        wr_count  = 0;
        wr_addr   = '0;
        wr_data   = '0;

        // data at 0x10..0x17 is jumped over by the branch at 0x0C
        put32(8'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
        put32(8'h04, enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'b0010011));
        put32(8'h08, enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
        put32(8'h0C, enc_b(13'd12, 5'd0, 5'd0, 3'b000));
        put32(8'h18, enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4));
        put32(8'h1C, enc_s(12'd16, 5'd3, 5'd0, LS_F3));
        put32(8'h20, enc_b(13'd8, 5'd1, 5'd1, 3'b000));
        put32(8'h24, 32'h0000_007F);
        put32(8'h28, enc_i(12'd16, 5'd0, LS_F3, 5'd5, 7'b0000011));
        put32(8'h2C, enc_b(13'd8, 5'd1, 5'd1, 3'b001));
        put32(8'h30, enc_s(12'h080, 5'd5, 5'd0, LS_F3));
        put32(8'h34, enc_s(12'h088, 5'd4, 5'd0, LS_F3));
        put32(8'h38, enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'b0010011));
        put32(8'h3C, enc_s(12'h090, 5'd0, 5'd0, LS_F3));
        put32(8'h40, 32'h0000_007F);

        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);

        reset = 1'b1;
        tick();
        check("first_req", 64'(mem_req), 64'd1);
        check("first_addr", 64'(mem_addr), 64'd0);
        check("first_we", 64'(mem_we), 64'd0);

        wait_retire("lat_addi1", 4);
        wait_retire("lat_addi2", 4);
        wait_retire("lat_add", 4);
        wait_retire("lat_beq0", 3);
        check("beq0_addr", 64'(mem_addr), 64'h18);
        check("beq0_pc", 64'(pc_out), 64'h18);
        wait_retire("lat_sub", 4);

        // sd x3,16(x0) with 3 wait cycles in FETCH and 3 in MEM
        check("sd_fetch_addr", 64'(mem_addr), 64'h1C);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_f_addr", 64'(mem_addr), 64'h1C);
            check("stall_f_req", 64'(mem_req), 64'd1);
            check("stall_f_retire", 64'(retire), 64'd0);
        end
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_m_addr", 64'(mem_addr), 64'd16);
            check("stall_m_we", 64'(mem_we), 64'd1);
            check("stall_m_wdata", 64'(mem_wdata), 64'd12);
            check("stall_m_retire", 64'(retire), 64'd0);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        check("sd_stall_retire", 64'(retire), 64'd1);
        check("sd_wr_count", 64'(wr_count), 64'd1);
        check("sd_wr_addr", 64'(wr_addr), 64'd16);
        check("sd_wr_data", 64'(wr_data), 64'd12);

        wait_retire("lat_beq_taken", 3);
        check("beq_addr", 64'(mem_addr), 64'h28);
        wait_retire("lat_ld", 5);
        wait_retire("lat_bne", 3);
        check("bne_addr", 64'(mem_addr), 64'h30);
        wait_retire("lat_sd_x5", 4);
        check("ld_x5_addr", 64'(wr_addr), 64'h80);
        check("ld_x5_data", 64'(wr_data), 64'd12);
        wait_retire("lat_sd_x4", 4);
        check("sub_x4_addr", 64'(wr_addr), 64'h88);
        check("sub_x4_data", 64'(wr_data), MINUS2);
        wait_retire("lat_addi_x0", 4);
        wait_retire("lat_sd_x0", 4);
        check("x0_data", 64'(wr_data), 64'd0);
        check("x0_count", 64'(wr_count), 64'd4);

        // illegal opcode at 0x40
        n = 0;
        do begin
            tick();
            n++;
        end while (!halted && n < 4);
        check("halt_lat", 64'(n), 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("halt_pc", 64'(pc_out), 64'h40);
            check("halt_req", 64'(mem_req), 64'd0);
            check("halt_retire", 64'(retire), 64'd0);
            check("halt_sticky", 64'(halted), 64'd1);
            tick();
        end
        check("halt_wr_count", 64'(wr_count), 64'd4);

        reset = 1'b0;
        tick();
        check("rst2_halted", 64'(halted), 64'd0);
        check("rst2_req", 64'(mem_req), 64'd0);
        check("rst2_pc", 64'(pc_out), 64'd0);
        reset = 1'b1;
        tick();
        check("rst2_fetch_req", 64'(mem_req), 64'd1);
        check("rst2_fetch_addr", 64'(mem_addr), 64'd0);

        // reset while a fetch is stalled abandons it
        mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst3_req", 64'(mem_req), 64'd0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        tick();
        check("rst3_fetch_req", 64'(mem_req), 64'd1);
        check("rst3_fetch_addr", 64'(mem_addr), 64'd0);
        wait_retire("rst3_lat_addi1", 4);
        check("rst3_pc", 64'(pc_out), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_riscv_core.md
MULTICYCLE_RISCV_CORE -- requirements
Module: multicycle_riscv_core

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/register/address width; legal values 32 or 64.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  memory transaction request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read.
REQ-007 SHALL have port mem_addr  output  XLEN  byte address.
REQ-008 SHALL have port mem_wdata  output  XLEN  store data.
REQ-009 SHALL have port mem_rdata  input  XLEN  read data; bits [31:0] carry the instruction on fetch.
REQ-010 SHALL have port mem_ready  input  1  transaction completes on an edge where mem_req and mem_ready are both 1.
REQ-011 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-012 SHALL have port halted  output  1  core stopped on an illegal instruction.
REQ-013 SHALL have port pc_out  output  XLEN  current PC.

Function
REQ-014 SHALL contain 32 x XLEN registers; x0 reads 0, writes to x0 ignored.
REQ-015 SHALL implement FSM states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; hold until mem_ready; then latch mem_rdata[31:0] as IR and go to DECODE.
REQ-017 DECODE: read rs1/rs2 into operand registers, generate sign-extended immediate (I, S, B formats); unsupported opcode/funct -> HALT.
REQ-018 Supported: add/sub/and/or (opcode 0110011, sub when funct7=0100000); addi (0010011, funct3 000); load (0000011) and store (0100011) with funct3 011 when XLEN=64, 010 when XLEN=32; beq/bne (1100011, funct3 000/001).
REQ-019 EXECUTE: ALU result registered; arithmetic is modulo 2^XLEN, no overflow detection.
REQ-020 EXECUTE, branch: if taken PC <= PC + immB else PC <= PC + 4; assert retire; go to FETCH.
REQ-021 EXECUTE, load/store -> MEM; R-type/addi -> WB.
REQ-022 MEM: mem_req=1, mem_addr=rs1+imm, mem_we=1 for store with mem_wdata=rs2; all outputs stable until mem_ready.
REQ-023 MEM completion, load: latch mem_rdata, go to WB; store: PC <= PC+4, retire, go to FETCH.
REQ-024 WB: write rd (ALU result or load data), PC <= PC+4, retire, go to FETCH.
REQ-025 Latency with mem_ready tied 1: branch 3 cycles, R/I 4, store 4, load 5; each wait cycle adds 1.
REQ-026 mem_req SHALL be 0 in DECODE, EXECUTE, WB, HALT; mem_we, mem_wdata don't-care when mem_req=0.
REQ-027 PC wraps modulo 2^XLEN; misaligned addresses passed unchanged, no trap.
REQ-028 HALT: sticky until reset; halted=1; no register, PC or memory changes; retire=0.
REQ-029 Instruction in HALT SHALL NOT retire; PC holds the illegal instruction address.

Reset
REQ-030 While reset=0 at an edge: state<=FETCH, PC<=RESET_PC, all registers<=0, IR<=0, retire=0, halted=0.
REQ-031 mem_req SHALL be 0 in the cycle following any reset edge, including mid-transaction; the pending transaction is abandoned.
REQ-032 First cycle after release: mem_req=1, mem_addr=RESET_PC.

Verification
REQ-033 addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2, ready=1 -> x3=12, x4=all-ones minus 1 (-2), 4 retire pulses 4 cycles apart.
REQ-034 sd x3,16(x0); ld x5,16(x0) against model memory -> write at addr 16 data 12, then x5=12; load takes 5 cycles.
REQ-035 beq x1,x1,+8 at PC 0x20 -> next fetch addr 0x28; bne x1,x1,+8 -> 0x24.
REQ-036 mem_ready held 0 for 3 cycles in FETCH and MEM -> mem_addr/mem_we/mem_wdata stable, latency +3 each, no retire early.
REQ-037 opcode 0x7F -> halted=1 within 2 cycles, pc_out frozen, mem_req=0; reset low one edge -> halted=0, fetch from RESET_PC.
REQ-038 addi x0,x0,9 -> x0 reads 0; XLEN=32 build repeats REQ-033/034 with lw/sw (funct3 010).
